// File: rtl/ysyx_23060059_axi_pkg.sv
// ysyx_23060059_axi_pkg
// Shared AXI4 definitions for the read slave and for the IFU/LSU/arbiter
// read paths: response codes, burst encodings, channel field widths and the
// read-responder state enum.
// Ports: none (package).
package ysyx_23060059_axi_pkg;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ysyx_23060059_lfsr16.sv
// ysyx_23060059_lfsr16
// 16-bit Fibonacci LFSR (taps 16,14,13,11), loaded with SEED on reset and
// stepped on every cycle that enable is high. Only used when the read slave
// is built with RAND_DELAY_EN, so the module is only compiled then as well.
// Ports:
//   clock  in  1   clock
//   reset  in  1   synchronous active-high reset (loads SEED)
//   enable in  1   advance one step
//   state  out 16  current LFSR state
`ifdef RAND_DELAY_EN
module ysyx_23060059_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Shift left, feeding back the XOR of bits 16,14,13,11 (1-based).
    always_comb begin
        state_d = state_q;
        if (enable) begin
            state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`endif

// File: rtl/ysyx_23060059_axi_rd_slave.sv
// ysyx_23060059_axi_rd_slave
// AXI4 read-channel responder (AR/R only) in front of a read-only 64-bit
// memory array 'mem'. One request at a time; LAT cycles from AR handshake to
// the first RVALID and LAT cycles from each beat handshake to the next beat.
// Every beat is decoded on its own address, so INCR bursts may run off the
// end of memory into DECERR. WRAP bursts and arsize>3 answer SLVERR.
// Optional build macro RAND_DELAY_EN: latency is 1 + (lfsr[3:0] % LAT)
// from a free-running 16-bit LFSR instead of the fixed LAT.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   araddr/arvalid/arid/arlen/arsize/arburst   AR channel inputs
//   arready                 AR accept
//   rdata/rresp/rlast/rid/rvalid               R channel outputs
//   rready                  R accept from master
module ysyx_23060059_axi_rd_slave
    import ysyx_23060059_axi_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          DEPTH = 4096,
    parameter int          LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    input  logic [ID_W-1:0]   arid,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [SIZE_W-1:0] arsize,
    input  logic [1:0]        arburst,
    output logic              arready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic              rvalid,
    input  logic              rready
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 3;
    localparam logic [3:0]  LAT_CNT   = 4'(LAT);

    // Preloaded by the environment; there is no write port.
    logic [63:0] mem [DEPTH];

    rd_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;

    logic [3:0]        cnt_load;
    logic [31:0]       beat_off;
    logic [63:0]       beat_data;
    logic [1:0]        beat_resp;

`ifdef RAND_DELAY_EN
    logic [15:0] lfsr_state;

    ysyx_23060059_lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .state  (lfsr_state)
    );

    always_comb begin
        cnt_load = 4'(1 + (int'(lfsr_state[3:0]) % LAT));
    end
`else
    always_comb begin
        cnt_load = LAT_CNT;
    end
`endif

    // Response for the current beat address. Protocol errors (WRAP, reserved
    // burst, oversize beat) take priority over the address decode.
    always_comb begin
        beat_off  = addr_q - BASE;
        beat_data = '0;
        beat_resp = RESP_OKAY;
        if (burst_q == BURST_WRAP || burst_q == 2'b11 || size_q > 3'd3) begin
            beat_resp = RESP_SLVERR;
        end else if (addr_q < BASE || {1'b0, beat_off} >= MEM_BYTES) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_data = mem[IDX_W'(beat_off >> 3)];
        end
    end

    // State register together with all datapath/output flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
        end
    end

    // Next-state logic. arready_q gates the AR handshake, so the first cycle
    // after reset (arready still low) cannot accept a request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arvalid && arready_q) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = DATA;
            DATA:    if (rready) state_d = rlast_q ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs. Leaving DATA on the last beat only
    // raises arready for the next cycle, so no AR is taken in the same cycle
    // as the final R handshake.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    rid_d     = arid;
                    cnt_d     = cnt_load;
                    arready_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d  = beat_data;
                    rresp_d  = beat_resp;
                    rlast_d  = (len_q == '0);
                    rvalid_d = 1'b1;
                end
            end
            DATA: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                    end else begin
                        if (burst_q == BURST_INCR) begin
                            addr_d = addr_q + (32'd1 << size_q);
                        end else if (burst_q == BURST_FIXED) begin
                            addr_d = addr_q;
                        end
                        len_d = len_q - 1'b1;
                        cnt_d = cnt_load;
                    end
                end
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

endmodule

// File: tb/tb_ysyx_23060059_axi_rd_slave.sv
// tb_ysyx_23060059_axi_rd_slave
// Directed bench for the AXI read slave at default parameters
// (BASE=8000_0000, DEPTH=4096, LAT=2). Inputs change 1 time unit after the
// rising edge; outputs are observed at the same point.
module tb_ysyx_23060059_axi_rd_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] M0    = 64'h00000013_00100093;
    localparam logic [63:0] M1    = 64'h11111111_22222222;
    localparam logic [63:0] M2    = 64'h33333333_44444444;
    localparam logic [63:0] M3    = 64'h55555555_66666666;
    localparam logic [63:0] MTOP  = 64'hDEADBEEF_CAFEF00D;

    ysyx_23060059_axi_rd_slave dut (
        .clock   (clock),
        .reset   (reset),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arid    (arid),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rid     (rid),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an AR request and return just after the handshake edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [7:0] len,
                                 input logic [2:0] sz, input logic [1:0] bu,
                                 input logic [3:0] id);
        int n;
        n = 0;
        araddr  = a;
        arlen   = len;
        arsize  = sz;
        arburst = bu;
        arid    = id;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("ar_accept", {63'd0, arready}, 64'd1);
        tick();
        arvalid = 1'b0;
    endtask

    // Count cycles until rvalid is seen, bounded.
    task automatic waitRvalid(output int n);
        n = 0;
        while (!rvalid && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int n;
        logic [63:0] exp_beats [4];
        reset   = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        arid    = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = 2'b01;
        rready  = 1'b1;

        dut.mem[0]    = M0;
        dut.mem[1]    = M1;
        dut.mem[2]    = M2;
        dut.mem[3]    = M3;
        dut.mem[4095] = MTOP;
        exp_beats[0] = M0;
        exp_beats[1] = M1;
        exp_beats[2] = M2;
        exp_beats[3] = M3;

        // Reset values
        tick();
        tick();
        checkOutput("rst_arready", {63'd0, arready}, 64'd0);
        checkOutput("rst_rvalid",  {63'd0, rvalid},  64'd0);
        checkOutput("rst_rlast",   {63'd0, rlast},   64'd0);
        checkOutput("rst_rresp",   {62'd0, rresp},   64'd0);
        checkOutput("rst_rid",     {60'd0, rid},     64'd0);
        checkOutput("rst_rdata",   rdata,            64'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_arready", {63'd0, arready}, 64'd1);

        // Single beat, LAT=2
        $display("[TB] single beat read");
        applyStimulus(32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd3);
        checkOutput("t1_rvalid_h0", {63'd0, rvalid}, 64'd0);
        checkOutput("t1_arready_h0", {63'd0, arready}, 64'd0);
        waitRvalid(n);
        checkOutput("t1_latency", 64'(n), 64'd2);
        checkOutput("t1_rdata", rdata, M0);
        checkOutput("t1_rresp", {62'd0, rresp}, 64'd0);
        checkOutput("t1_rlast", {63'd0, rlast}, 64'd1);
        checkOutput("t1_rid",   {60'd0, rid},   64'd3);
        checkOutput("t1_arready_data", {63'd0, arready}, 64'd0);
        tick();
        checkOutput("t1_rvalid_done", {63'd0, rvalid}, 64'd0);
        checkOutput("t1_arready_next", {63'd0, arready}, 64'd1);

        // INCR burst of 4 doublewords
        $display("[TB] incr burst");
        applyStimulus(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd5);
        for (int k = 0; k < 4; k++) begin
            waitRvalid(n);
            checkOutput($sformatf("t2_gap%0d", k), 64'(n), 64'd2);
            checkOutput($sformatf("t2_rdata%0d", k), rdata, exp_beats[k]);
            checkOutput($sformatf("t2_rresp%0d", k), {62'd0, rresp}, 64'd0);
            checkOutput($sformatf("t2_rlast%0d", k), {63'd0, rlast}, (k == 3) ? 64'd1 : 64'd0);
            checkOutput($sformatf("t2_rid%0d", k), {60'd0, rid}, 64'd5);
            tick();
            checkOutput($sformatf("t2_rvalid_low%0d", k), {63'd0, rvalid}, 64'd0);
        end
        checkOutput("t2_arready_end", {63'd0, arready}, 64'd1);

        // Backpressure: rready low for 5 cycles
        $display("[TB] backpressure");
        rready = 1'b0;
        applyStimulus(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'd7);
        waitRvalid(n);
        checkOutput("t3_latency", 64'(n), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("t3_hold_rvalid%0d", k), {63'd0, rvalid}, 64'd1);
            checkOutput($sformatf("t3_hold_rdata%0d", k), rdata, M1);
            checkOutput($sformatf("t3_hold_rlast%0d", k), {63'd0, rlast}, 64'd1);
            checkOutput($sformatf("t3_hold_rid%0d", k), {60'd0, rid}, 64'd7);
        end
        rready = 1'b1;
        tick();
        checkOutput("t3_done_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("t3_done_arready", {63'd0, arready}, 64'd1);

        // Out-of-range address
        $display("[TB] decode error");
        applyStimulus(32'h0000_1000, 8'd0, 3'd3, 2'b01, 4'd1);
        waitRvalid(n);
        checkOutput("t4_rresp", {62'd0, rresp}, 64'd3);
        checkOutput("t4_rdata", rdata, 64'd0);
        checkOutput("t4_rlast", {63'd0, rlast}, 64'd1);
        tick();

        // INCR burst crossing the top of memory
        applyStimulus(32'h8000_7FF8, 8'd1, 3'd3, 2'b01, 4'd2);
        waitRvalid(n);
        checkOutput("t5_b0_rresp", {62'd0, rresp}, 64'd0);
        checkOutput("t5_b0_rdata", rdata, MTOP);
        checkOutput("t5_b0_rlast", {63'd0, rlast}, 64'd0);
        tick();
        waitRvalid(n);
        checkOutput("t5_b1_rresp", {62'd0, rresp}, 64'd3);
        checkOutput("t5_b1_rdata", rdata, 64'd0);
        checkOutput("t5_b1_rlast", {63'd0, rlast}, 64'd1);
        tick();

        // WRAP burst -> SLVERR on both beats
        $display("[TB] slave errors");
        applyStimulus(32'h8000_0000, 8'd1, 3'd3, 2'b10, 4'd4);
        waitRvalid(n);
        checkOutput("t6_b0_rresp", {62'd0, rresp}, 64'd2);
        checkOutput("t6_b0_rdata", rdata, 64'd0);
        checkOutput("t6_b0_rlast", {63'd0, rlast}, 64'd0);
        tick();
        waitRvalid(n);
        checkOutput("t6_b1_rresp", {62'd0, rresp}, 64'd2);
        checkOutput("t6_b1_rlast", {63'd0, rlast}, 64'd1);
        tick();

        // Oversize beat
        applyStimulus(32'h8000_0000, 8'd0, 3'd4, 2'b01, 4'd6);
        waitRvalid(n);
        checkOutput("t7_rresp", {62'd0, rresp}, 64'd2);
        checkOutput("t7_rdata", rdata, 64'd0);
        tick();

        // Reset during WAIT of a 4-beat burst
        $display("[TB] reset mid-burst");
        applyStimulus(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd8);
        reset = 1'b1;
        tick();
        checkOutput("t8_rst_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("t8_rst_arready", {63'd0, arready}, 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("t8_post_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("t8_post_arready", {63'd0, arready}, 64'd1);
        applyStimulus(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd9);
        waitRvalid(n);
        checkOutput("t8_latency", 64'(n), 64'd2);
        checkOutput("t8_rdata", rdata, M2);
        checkOutput("t8_rresp", {62'd0, rresp}, 64'd0);
        checkOutput("t8_rlast", {63'd0, rlast}, 64'd1);
        checkOutput("t8_rid", {60'd0, rid}, 64'd9);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
